nios_test_nios2_qsys_0_ocimem_ctrl: RTL and testbench

//  Downstream consumer of the JTAG debug module sysclk-side outputs (jdo, take_*_ocimem_*).

---
 rtl/nios_test_ocimem_pkg.sv | 37 +++
 rtl/nios_test_nios2_qsys_0_ocimem_ctrl_if.sv | 22 ++
 rtl/nios_test_ocimem_ram.sv | 23 ++
 rtl/nios_test_nios2_qsys_0_ocimem_ctrl.sv | 123 ++++++++++++
 tb/tb_nios_test_nios2_qsys_0_ocimem_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_test_ocimem_pkg.sv
// Shared types and constants for the on-chip debug RAM controller.
package nios_test_ocimem_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned BE_W      = DATA_W / 8;
    localparam int unsigned JDO_W     = 38;
    localparam int unsigned ADDR_LSB  = 25;
    localparam int unsigned RDFLAG    = 34;
    localparam int unsigned WDATA_MSB = 34;
    localparam int unsigned WDATA_LSB = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_JRD     = 3'd1,
        ST_JRD_CAP = 3'd2,
        ST_JWR     = 3'd3,
        ST_CRD     = 3'd4,
        ST_CWR     = 3'd5,
        ST_CACK    = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_RD   = 2'd1,
        OP_WR   = 2'd2
    } op_t;

    typedef struct packed {
        op_t               op;
        logic [DATA_W-1:0] data;
    } jtag_op_t;

    function automatic logic is_jtag_state(input state_t s);
        return s inside {ST_JRD, ST_JRD_CAP, ST_JWR};
    endfunction

endpackage

// File: rtl/nios_test_nios2_qsys_0_ocimem_ctrl_if.sv
// Avalon-MM slave bundle through which the CPU reaches the debug RAM.
interface nios_test_nios2_qsys_0_ocimem_ctrl_if #(
    parameter int unsigned ADDR_W = 9
) ();
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [3:0]        avs_byteenable;
    logic [31:0]       avs_readdata;
    logic              avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/nios_test_ocimem_ram.sv
// Single-port debug RAM: byte-enabled write, one-cycle registered read.
module nios_test_ocimem_ram
    import nios_test_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BE_W-1:0]   we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
        q <= mem[addr];
    end
endmodule

// File: rtl/nios_test_nios2_qsys_0_ocimem_ctrl.sv
// Debug RAM controller: serves JTAG debug-module ops (with priority) and
// Avalon-MM CPU transfers on one single-port RAM.
module nios_test_nios2_qsys_0_ocimem_ctrl
    import nios_test_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [DATA_W-1:0] MonDReg,
    output logic              jtag_busy,
    nios_test_nios2_qsys_0_ocimem_ctrl_if.slave avs
);
    state_t            state, next_state;
    jtag_op_t          pend, pend_next;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] mon_areg;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;
    logic              any_pulse;
    logic [ADDR_W-1:0] ram_addr;
    logic [BE_W-1:0]   ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;
    logic              unused_jdo;

    assign any_pulse  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign unused_jdo = ^{jdo[JDO_W-1:WDATA_MSB+1], jdo[WDATA_LSB-1:0]};

    // One-entry pending op; newest pulse replaces whatever is waiting.
    always_comb begin
        pend_next = pend;
        if (state == ST_IDLE && !any_pulse) pend_next.op = OP_NONE;
        if (take_action_ocimem_b) begin
            pend_next.op   = OP_WR;
            pend_next.data = jdo[WDATA_MSB:WDATA_LSB];
        end else if (take_no_action_ocimem_a) begin
            pend_next.op = OP_RD;
        end else if (take_action_ocimem_a) begin
            pend_next.op = jdo[RDFLAG] ? OP_RD : OP_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // A pulse arriving in IDLE holds off the CPU until it has been latched.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (any_pulse)              next_state = ST_IDLE;
                else if (pend.op == OP_RD)  next_state = ST_JRD;
                else if (pend.op == OP_WR)  next_state = ST_JWR;
                else if (avs.avs_read)      next_state = ST_CRD;
                else if (avs.avs_write)     next_state = ST_CWR;
            end
            ST_JRD:     next_state = ST_JRD_CAP;
            ST_JRD_CAP: next_state = ST_IDLE;
            ST_JWR:     next_state = ST_IDLE;
            ST_CRD:     next_state = ST_CACK;
            ST_CWR:     next_state = ST_CACK;
            ST_CACK:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // RAM port steering; the CPU address is presented by default so a CPU read's data is in q during CRD.
    always_comb begin
        ram_addr  = avs.avs_address;
        ram_we    = '0;
        ram_wdata = avs.avs_writedata;
        case (state)
            ST_JRD: ram_addr = mon_areg;
            ST_JWR: begin
                ram_addr  = mon_areg;
                ram_we    = {BE_W{1'b1}};
                ram_wdata = wr_data;
            end
            ST_CWR:  ram_we = avs.avs_byteenable;
            default: ;
        endcase
        if (reset) ram_we = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend        <= '{op: OP_NONE, data: '0};
            wr_data     <= '0;
            mon_areg    <= '0;
            MonDReg     <= '0;
            readdata    <= '0;
            waitrequest <= 1'b1;
            jtag_busy   <= 1'b0;
        end else begin
            pend        <= pend_next;
            waitrequest <= (next_state != ST_CACK);
            jtag_busy   <= (pend_next.op != OP_NONE) || is_jtag_state(next_state);
            if (state == ST_IDLE && next_state == ST_JWR) wr_data <= pend.data;
            if (state == ST_JRD_CAP) MonDReg <= ram_q;
            if (state == ST_CRD) readdata <= ram_q;
            if (take_action_ocimem_a) mon_areg <= jdo[ADDR_LSB +: ADDR_W];
            else if (state == ST_JRD_CAP || state == ST_JWR) mon_areg <= mon_areg + ADDR_W'(1);
        end
    end

    assign avs.avs_readdata    = readdata;
    assign avs.avs_waitrequest = waitrequest;

    nios_test_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .q     (ram_q)
    );
endmodule

// File: tb/tb_nios_test_nios2_qsys_0_ocimem_ctrl.sv
// Directed plus randomized bench for the debug RAM controller against a word-array model.
module tb_nios_test_nios2_qsys_0_ocimem_ctrl;
    import nios_test_ocimem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [37:0] jdo;
    logic        take_a, take_b, take_na;
    logic [31:0] MonDReg;
    logic        jtag_busy;

    nios_test_nios2_qsys_0_ocimem_ctrl_if #(.ADDR_W(9)) avs ();

    nios_test_nios2_qsys_0_ocimem_ctrl #(.ADDR_W(9)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_na),
        .MonDReg                 (MonDReg),
        .jtag_busy               (jtag_busy),
        .avs                     (avs)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] ref_mem [512];
    logic [8:0]  ref_areg;
    logic [31:0] ref_mond;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic jtag_load(input logic [8:0] addr);
        jdo = '0;
        jdo[ADDR_LSB +: 9] = addr;
        take_a = 1'b1;
        step();
        take_a = 1'b0;
        ref_areg = addr;
        chk("load_busy", 32'(jtag_busy), 32'd0);
    endtask

    task automatic jtag_write(input logic [31:0] data);
        jdo = '0;
        jdo[WDATA_MSB:WDATA_LSB] = data;
        take_b = 1'b1;
        step();
        take_b = 1'b0;
        chk("wr_busy", 32'(jtag_busy), 32'd1);
        step();
        step();
        chk("wr_done", 32'(jtag_busy), 32'd0);
        ref_mem[ref_areg] = data;
        ref_areg = ref_areg + 9'd1;
    endtask

    task automatic jtag_read(input bit load, input logic [8:0] addr);
        logic [31:0] exp;
        if (load) ref_areg = addr;
        exp = ref_mem[ref_areg];
        jdo = '0;
        jdo[ADDR_LSB +: 9] = addr;
        jdo[RDFLAG] = 1'b1;
        if (load) take_a = 1'b1;
        else      take_na = 1'b1;
        step();
        take_a  = 1'b0;
        take_na = 1'b0;
        chk("rd_busy", 32'(jtag_busy), 32'd1);
        step();
        step();
        chk("rd_not_early", MonDReg, ref_mond);
        step();
        chk("rd_data", MonDReg, exp);
        chk("rd_idle", 32'(jtag_busy), 32'd0);
        ref_mond = exp;
        ref_areg = ref_areg + 9'd1;
    endtask

    task automatic cpu_wait(output int k, output logic [31:0] rd);
        k  = 0;
        rd = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            k = i + 1;
            if (avs.avs_waitrequest === 1'b0) break;
        end
        chk("cpu_ack", 32'(avs.avs_waitrequest), 32'd0);
        rd = avs.avs_readdata;
        step();
        avs.avs_read  = 1'b0;
        avs.avs_write = 1'b0;
        chk("cpu_ack_one_cycle", 32'(avs.avs_waitrequest), 32'd1);
    endtask

    task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
        int          k;
        logic [31:0] rd;
        avs.avs_address    = a;
        avs.avs_writedata  = d;
        avs.avs_byteenable = be;
        avs.avs_write      = 1'b1;
        cpu_wait(k, rd);
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic cpu_read(input logic [8:0] a, output int k, output logic [31:0] rd);
        avs.avs_address = a;
        avs.avs_read    = 1'b1;
        cpu_wait(k, rd);
    endtask

    // CPU read and JTAG read in contention; cycles counted from the JTAG pulse cycle.
    task automatic race(input bit cpu_first, input logic [31:0] exp_j,
                        output int mon_k, output int ack_k, output logic [31:0] rd);
        mon_k = -1;
        ack_k = -1;
        rd    = '0;
        avs.avs_read = 1'b1;
        if (cpu_first) step();
        take_na = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            take_na = 1'b0;
            if (ack_k >= 0) avs.avs_read = 1'b0;
            if (mon_k < 0 && MonDReg === exp_j) mon_k = k;
            if (ack_k < 0 && avs.avs_waitrequest === 1'b0) begin
                ack_k = k;
                rd    = avs.avs_readdata;
            end
        end
        avs.avs_read = 1'b0;
        ref_mond = exp_j;
        ref_areg = ref_areg + 9'd1;
    endtask

    initial begin
        int          k, mon_k, ack_k, lows;
        logic [31:0] rd, a_val, b_val;

        reset = 1'b1;
        jdo = '0; take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
        avs.avs_address = '0; avs.avs_read = 1'b0; avs.avs_write = 1'b0;
        avs.avs_writedata = '0; avs.avs_byteenable = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        ref_areg = '0;
        ref_mond = '0;
        step(); step(); step();
        chk("rst_mondreg", MonDReg, 32'd0);
        chk("rst_busy", 32'(jtag_busy), 32'd0);
        chk("rst_wait", 32'(avs.avs_waitrequest), 32'd1);
        chk("rst_rdata", avs.avs_readdata, 32'd0);
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (avs.avs_waitrequest !== 1'b1) lows++;
        end
        chk("idle_no_ack", 32'(lows), 32'd0);
        chk("idle_busy", 32'(jtag_busy), 32'd0);

        // JTAG write then read-back with auto-increment
        jtag_load(9'h010);
        jtag_write(32'hDEADBEEF);
        jtag_write(32'hCAFEF00D);
        jtag_load(9'h010);
        jtag_read(1'b0, 9'h0);
        chk("mon_deadbeef", MonDReg, 32'hDEADBEEF);
        jtag_read(1'b0, 9'h0);

        // CPU byte-enabled write and read
        cpu_write(9'd5, 32'hFFFFFFFF, 4'hF);
        cpu_write(9'd5, 32'h12345678, 4'b0011);
        cpu_read(9'd5, k, rd);
        chk("cpu_rd_merge", rd, 32'hFFFF5678);
        chk("cpu_rd_latency", 32'(k), 32'd2);

        // Simultaneous CPU read and JTAG read: JTAG served first
        jtag_load(9'h010);
        avs.avs_address = 9'd5;
        race(1'b0, ref_mem[9'h010], mon_k, ack_k, rd);
        chk("race_mon_k", 32'(mon_k), 32'd4);
        chk("race_ack_k", 32'(ack_k), 32'd6);
        chk("race_gap", 32'(ack_k - mon_k), 32'd2);
        chk("race_cpu_data", rd, 32'hFFFF5678);

        // Address wrap at top of RAM
        a_val = 32'hA5A50001;
        b_val = 32'h5A5A0002;
        jtag_load(9'h1FF);
        jtag_write(a_val);
        jtag_write(b_val);
        chk("wrap_areg", 32'(ref_areg), 32'd1);
        cpu_read(9'h1FF, k, rd);
        chk("wrap_word_1ff", rd, a_val);
        cpu_read(9'h000, k, rd);
        chk("wrap_word_000", rd, b_val);
        jtag_read(1'b1, 9'h1FF);
        jtag_read(1'b0, 9'h0);

        // Reset while in JRD_CAP with a CPU read waiting
        avs.avs_address = 9'd5;
        avs.avs_read = 1'b1;
        take_na = 1'b1;
        step();
        take_na = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk("rst_mid_mondreg", MonDReg, 32'd0);
        chk("rst_mid_wait", 32'(avs.avs_waitrequest), 32'd1);
        avs.avs_read = 1'b0;
        step();
        reset = 1'b0;
        ref_mond = '0;
        ref_areg = '0;
        lows = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (avs.avs_waitrequest !== 1'b1) lows++;
        end
        chk("rst_mid_no_ack", 32'(lows), 32'd0);
        chk("rst_mid_busy", 32'(jtag_busy), 32'd0);
        jtag_read(1'b0, 9'h0);

        // Fill the whole RAM through JTAG; the address wraps back to 0
        jtag_load(9'h000);
        for (int i = 0; i < 512; i++) jtag_write($urandom);
        chk("fill_wrap", 32'(ref_areg), 32'd0);

        // CPU op in flight delays the JTAG read by at most 2 cycles
        jtag_load(9'h020);
        jtag_write(~ref_mond);
        jtag_load(9'h020);
        avs.avs_address = 9'h033;
        race(1'b1, ref_mem[9'h020], mon_k, ack_k, rd);
        chk("inflight_cpu_first", 32'(ack_k), 32'd1);
        chk("inflight_mon_bound", 32'(mon_k >= 4 && mon_k <= 6), 32'd1);
        chk("inflight_cpu_data", rd, ref_mem[9'h033]);

        // Randomized mix of operations
        for (int i = 0; i < 80; i++) begin
            logic [8:0]  ra;
            logic [31:0] rdat;
            ra   = 9'($urandom);
            rdat = $urandom;
            case ($urandom_range(4))
                0: cpu_write(ra, rdat, 4'($urandom));
                1: begin
                    cpu_read(ra, k, rd);
                    chk("rnd_cpu_rd", rd, ref_mem[ra]);
                end
                2: jtag_read(1'b1, ra);
                3: jtag_read(1'b0, 9'h0);
                default: jtag_write(rdat);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
